ps2_key_ctrl: RTL
=================

Name: ps2_key_ctrl

Overview:
Keyboard front-end controller for the game core. It samples the raw PS/2 clock/data lines, assembles and checks 11-bit frames, and interprets E0/F0 prefix sequences. Recognised make codes become game commands, which are queued in a small FIFO. The game FSM consumes the queue through a valid/ready handshake. The block sits between the board PS/2 pins and the game control FSM inside ctrl_main_block, and exports the last scancode for the test LEDs.

Parameters:
TIMEOUT_CYCLES, 20000, clk cycles without a ps2_clk falling edge before an in-progress frame is aborted
FIFO_DEPTH, 4, command queue entries (power of 2, min 2)
SYNC_STAGES, 2, synchroniser flops on ps2_clk and ps2_data

Ports:
clk  in  1  system/pixel clock, 25 MHz
reset  in  1  synchronous, active-low reset
ps2_clk  in  1  PS/2 clock pin, asynchronous
ps2_data  in  1  PS/2 data pin, asynchronous
cmd  out  4  command code (cmd_t), valid when cmd_valid
cmd_valid  out  1  FIFO not empty
cmd_ready  in  1  consumer accepts head entry
last_scan  out  8  last correctly received byte, including prefixes
err_parity  out  1  one-cycle pulse on a parity error
err_frame  out  1  one-cycle pulse on a bad start/stop bit or a timeout
overflow  out  1  one-cycle pulse when a command is dropped because the FIFO is full

Behaviour:
- Reset (reset==0 at posedge clk):
  - All outputs 0, FIFO empty.
  - Frame FSM returns to IDLE; ext/brk flags are cleared.
  - Synchronisers are preset to 1.
  - A reset mid-frame discards the partial frame.
- Sampling:
  - ps2_clk and ps2_data each pass through SYNC_STAGES flops.
  - A falling edge means the previous synced ps2_clk was 1 and the current one is 0.
  - Data is sampled only in that edge cycle (cycle F).
- Frame FSM, states IDLE, DATA, PARITY, STOP:
  - IDLE: an edge with data=0 goes to DATA, bit counter=0. An edge with data=1 is ignored and stays in IDLE.
  - DATA: shift LSB-first. After the 8th bit, go to PARITY.
  - PARITY: store the bit, go to STOP.
  - STOP: always return to IDLE.
    - If data=1 and the XOR of the 8 bits plus parity is 1, the byte is accepted: byte_stb at F+1 and last_scan updated at F+1.
    - If stop is 0, pulse err_frame.
    - If parity fails (stop good), pulse err_parity.
    - A frame that fails either check is discarded.
  - A timeout counter resets on every edge and counts only outside IDLE. Reaching TIMEOUT_CYCLES forces IDLE and pulses err_frame.
- Decoder, acting on byte_stb:
  - 0xE0 sets ext.
  - 0xF0 sets brk.
  - Any other byte: if brk, it is a release; clear both flags and push nothing. Otherwise map it, clear both flags, and push if mapped.
  - Map without ext: 1D→UP, 1B→DOWN, 1C→LEFT, 23→RIGHT, 29→SPACE, 5A→ENTER, 76→ESC, 35→YES, 31→NO.
  - Map with ext: 75→UP, 72→DOWN, 6B→LEFT, 74→RIGHT.
  - Unmapped codes are ignored silently.
- FIFO:
  - Write at the end of F+1; cmd_valid is visible at F+2.
  - Pop when cmd_valid&&cmd_ready; cmd shows the new head on the next cycle.
  - Push while full: drop the new entry and pulse overflow. If a pop occurs in the same cycle, the push succeeds instead.
  - Push while empty writes normally.
  - Pointers wrap modulo FIFO_DEPTH and use an extra MSB for the full/empty distinction.
- cmd holds its last value when not valid (not cleared).

Optional Feature:
KEY_REPEAT_FILTER_EN
- Defined: the block tracks the held key as {ext, code}, 9 bits.
  - A make equal to the held key, with no release in between, is not pushed (typematic repeat suppressed).
  - A release of the held key clears the tracking.
  - A different make replaces it.
- Undefined: every make is pushed, including repeats.

Decomposition:
- Package ps2_key_pkg:
  - cmd_t enum (4-bit): NONE=0, UP, DOWN, LEFT, RIGHT, SPACE, ENTER, ESC, YES, NO.
  - Scancode localparams (U_KEY..ESC_KEY, the arrow codes, BRK_CODE=8'hF0, EXT_CODE=8'hE0).
- Sub-module ps2_rx_frame: synchroniser, edge detect, frame FSM and timeout; outputs byte, byte_stb, err_parity, err_frame.
- The decoder and FIFO live in ps2_key_ctrl.

Test Plan:
1. cmd_ready=1, send 29 then F0 29 (1500-cycle bit period) → cmd_valid=1 for exactly one cycle at F+2 with cmd=SPACE; no command for the break; last_scan=0x29 then 0xF0 then 0x29.
2. Send E0 75, then E0 F0 75 → one UP command; no command for the release; flags clear after each sequence.
3. Send 1B with the parity bit inverted → err_parity pulse, no command. A following good 1B → DOWN.
4. cmd_ready=0, send makes 1D,1B,1C,23,5A → cmd_valid=1 after the first; overflow pulses on the 5th. Then set ready=1 → pops UP,DOWN,LEFT,RIGHT in order; cmd_valid falls after 4 pops.
5. Stop a frame after 4 data bits and stay idle for 20000 cycles → err_frame pulse, FSM in IDLE. Next good frame 76 → ESC.
6. Pull reset low mid-frame → all outputs 0 the next cycle, FIFO empty. Then, after releasing reset, send 1D,1D,1D,F0 1D → 1 UP with KEY_REPEAT_FILTER_EN defined, 3 UP without it.

Source files
------------

// File: rtl/ps2_key_pkg.sv
// Shared types and scancode constants for the PS/2 keyboard front-end.
// Command codes, set-2 scancodes, and the scancode-to-command map.
package ps2_key_pkg;

  typedef enum logic [3:0] {
    NONE  = 4'd0,
    UP    = 4'd1,
    DOWN  = 4'd2,
    LEFT  = 4'd3,
    RIGHT = 4'd4,
    SPACE = 4'd5,
    ENTER = 4'd6,
    ESC   = 4'd7,
    YES   = 4'd8,
    NO    = 4'd9
  } cmd_t;

  localparam logic [7:0] U_KEY       = 8'h1D;
  localparam logic [7:0] D_KEY       = 8'h1B;
  localparam logic [7:0] L_KEY       = 8'h1C;
  localparam logic [7:0] R_KEY       = 8'h23;
  localparam logic [7:0] SPACE_KEY   = 8'h29;
  localparam logic [7:0] ENTER_KEY   = 8'h5A;
  localparam logic [7:0] ESC_KEY     = 8'h76;
  localparam logic [7:0] Y_KEY       = 8'h35;
  localparam logic [7:0] N_KEY       = 8'h31;
  localparam logic [7:0] UP_ARROW    = 8'h75;
  localparam logic [7:0] DOWN_ARROW  = 8'h72;
  localparam logic [7:0] LEFT_ARROW  = 8'h6B;
  localparam logic [7:0] RIGHT_ARROW = 8'h74;
  localparam logic [7:0] BRK_CODE    = 8'hF0;
  localparam logic [7:0] EXT_CODE    = 8'hE0;

  // Extended (E0-prefixed) codes only map the arrow keys; anything else is NONE.
  function automatic cmd_t map_code(input logic ext, input logic [7:0] code);
    cmd_t c;
    c = NONE;
    if (ext) begin
      case (code)
        UP_ARROW:    c = UP;
        DOWN_ARROW:  c = DOWN;
        LEFT_ARROW:  c = LEFT;
        RIGHT_ARROW: c = RIGHT;
        default:     c = NONE;
      endcase
    end else begin
      case (code)
        U_KEY:     c = UP;
        D_KEY:     c = DOWN;
        L_KEY:     c = LEFT;
        R_KEY:     c = RIGHT;
        SPACE_KEY: c = SPACE;
        ENTER_KEY: c = ENTER;
        ESC_KEY:   c = ESC;
        Y_KEY:     c = YES;
        N_KEY:     c = NO;
        default:   c = NONE;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 receive path: synchronisers, falling-edge detect, 11-bit frame FSM
// (start, 8 data LSB-first, odd parity, stop) and inter-edge timeout.
// SYNC_STAGES must be at least 2.
module ps2_rx_frame
  import ps2_key_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_stb,
  output logic       err_parity,
  output logic       err_frame
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic                   clk_prev;
  logic                   fall, data_s;
  logic [1:0]             state;
  logic [2:0]             bit_cnt;
  logic [7:0]             shreg;
  logic                   par_bit;
  logic [TW-1:0]          tcnt;

  // Synchronisers idle high so a released line never looks like an edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign fall   = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign data_s = dat_sync[SYNC_STAGES-1];

  // Frame FSM plus timeout; status pulses are registered so they land at F+1.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      tcnt       <= '0;
      rx_byte    <= '0;
      byte_stb   <= 1'b0;
      err_parity <= 1'b0;
      err_frame  <= 1'b0;
    end else begin
      byte_stb   <= 1'b0;
      err_parity <= 1'b0;
      err_frame  <= 1'b0;
      if (state == S_IDLE || fall) begin
        tcnt <= '0;
      end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
        // Line stalled mid-frame: abandon it.
        tcnt      <= '0;
        state     <= S_IDLE;
        err_frame <= 1'b1;
      end else begin
        tcnt <= tcnt + 1'b1;
      end
      if (fall) begin
        case (state)
          S_IDLE: begin
            if (!data_s) begin
              state   <= S_DATA;
              bit_cnt <= '0;
            end
          end
          S_DATA: begin
            shreg   <= {data_s, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= S_PARITY;
          end
          S_PARITY: begin
            par_bit <= data_s;
            state   <= S_STOP;
          end
          default: begin
            state <= S_IDLE;
            if (!data_s) begin
              err_frame <= 1'b1;
            end else if (^{shreg, par_bit}) begin
              rx_byte  <= shreg;
              byte_stb <= 1'b1;
            end else begin
              err_parity <= 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/ps2_key_ctrl.sv
// Keyboard front-end: PS/2 frame receiver, E0/F0 prefix decoder, command
// mapping and a small command FIFO drained by a valid/ready handshake.
// Optional build macro KEY_REPEAT_FILTER_EN suppresses typematic repeats of
// the currently held key.
module ps2_key_ctrl
  import ps2_key_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int FIFO_DEPTH     = 4,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [3:0] cmd,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [7:0] last_scan,
  output logic       err_parity,
  output logic       err_frame,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0] rx_byte;
  logic       byte_stb;

  ps2_rx_frame #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_rx (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rx_byte    (rx_byte),
    .byte_stb   (byte_stb),
    .err_parity (err_parity),
    .err_frame  (err_frame)
  );

  logic ext, brk, is_prefix, push;
  cmd_t push_cmd;

  assign is_prefix = (rx_byte == EXT_CODE) || (rx_byte == BRK_CODE);

`ifdef KEY_REPEAT_FILTER_EN
  logic       held_vld;
  logic [8:0] held;
  logic       held_hit;
  assign held_hit = held_vld && (held == {ext, rx_byte});
`endif

  // A make code pushes only when it maps to a command (and isn't a repeat).
  always_comb begin
    push_cmd = map_code(ext, rx_byte);
    push     = byte_stb && !is_prefix && !brk && (push_cmd != NONE);
`ifdef KEY_REPEAT_FILTER_EN
    if (held_hit) push = 1'b0;
`endif
  end

  // Prefix flags, held-key tracking and the scancode mirror for the LEDs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ext       <= 1'b0;
      brk       <= 1'b0;
      last_scan <= '0;
`ifdef KEY_REPEAT_FILTER_EN
      held_vld  <= 1'b0;
      held      <= '0;
`endif
    end else if (byte_stb) begin
      last_scan <= rx_byte;
      if (rx_byte == EXT_CODE) begin
        ext <= 1'b1;
      end else if (rx_byte == BRK_CODE) begin
        brk <= 1'b1;
      end else begin
        ext <= 1'b0;
        brk <= 1'b0;
`ifdef KEY_REPEAT_FILTER_EN
        if (brk) begin
          if (held_hit) held_vld <= 1'b0;
        end else begin
          held_vld <= 1'b1;
          held     <= {ext, rx_byte};
        end
`endif
      end
    end
  end

  cmd_t        mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr, wptr_n, rptr_n;
  logic        full, empty, pop, push_ok;
  cmd_t        cmd_q, cmd_next;

  assign empty     = (wptr == rptr);
  assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop       = !empty && cmd_ready;
  assign push_ok   = push && (!full || pop);
  assign cmd_valid = !empty;
  assign cmd       = cmd_q;

  // Next head: the entry being written this cycle if it becomes the head,
  // otherwise the stored one; hold the old value when the queue goes empty.
  always_comb begin
    wptr_n   = wptr + (AW+1)'(push_ok);
    rptr_n   = rptr + (AW+1)'(pop);
    cmd_next = cmd_q;
    if (wptr_n != rptr_n) begin
      if (rptr_n == wptr) cmd_next = push_cmd;
      else                cmd_next = mem[rptr_n[AW-1:0]];
    end
  end

  // Storage array needs no reset; pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr[AW-1:0]] <= push_cmd;
  end

  // Pointers, registered head and overflow pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr     <= '0;
      rptr     <= '0;
      cmd_q    <= NONE;
      overflow <= 1'b0;
    end else begin
      wptr     <= wptr_n;
      rptr     <= rptr_n;
      cmd_q    <= cmd_next;
      overflow <= push && full && !pop;
    end
  end

endmodule
